// File: rtl/apb_node_pipe.sv
// APB 1-to-N address-decoding node with a registered SETUP/ACCESS pipeline.
// Define APB_NODE_PIPE_TIMEOUT_EN to bound downstream ACCESS wait cycles.
module apb_node_pipe #(
    parameter int NB_MASTER      = 8,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          psel_i,
    input  logic                                          penable_i,
    input  logic                                          pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                     paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                     pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]                     prdata_o,
    output logic                                          pready_o,
    output logic                                          pslverr_o,
    output logic [NB_MASTER-1:0]                          psel_o,
    output logic [NB_MASTER-1:0]                          penable_o,
    output logic [NB_MASTER-1:0]                          pwrite_o,
    output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      paddr_o,
    output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      pwdata_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
    input  logic [NB_MASTER-1:0]                          pready_i,
    input  logic [NB_MASTER-1:0]                          pslverr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      START_ADDR_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      END_ADDR_i
);

    localparam int SEL_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_tmo_range
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP,
        ERR
    } state_t;

    state_t state_q, state_d;

    logic [SEL_W-1:0]          sel_q;
    logic [SEL_W-1:0]          dec_idx;
    logic                      dec_hit;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] prdata_q;
    logic                      pslverr_q;
    logic                      setup_req;
    logic                      sel_ready;
    logic                      tmo_hit;

    assign setup_req = psel_i & ~penable_i;
    assign sel_ready = pready_i[sel_q];

    // Walk from the top down so the lowest matching window wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (paddr_i >= START_ADDR_i[i] && paddr_i <= END_ADDR_i[i]) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
            end
        end
    end

`ifdef APB_NODE_PIPE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt <= '0;
        end else if (state_q == ACCESS && !sel_ready) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Fires on the cycle whose miss brings the count to TIMEOUT_CYCLES.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (setup_req) begin
                    state_d = dec_hit ? SETUP : ERR;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (sel_ready) begin
                    state_d = RESP;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response registers change only when entering RESP or ERR.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pwrite_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            if (state_q == IDLE && setup_req) begin
                sel_q    <= dec_idx;
                addr_q   <= paddr_i;
                wdata_q  <= pwdata_i;
                pwrite_q <= pwrite_i;
                if (!dec_hit) begin
                    prdata_q  <= '0;
                    pslverr_q <= 1'b1;
                end
            end
            if (state_q == ACCESS) begin
                if (sel_ready) begin
                    prdata_q  <= prdata_i[sel_q];
                    pslverr_q <= pslverr_i[sel_q];
                end else if (tmo_hit) begin
                    prdata_q  <= '0;
                    pslverr_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        psel_o    = '0;
        penable_o = '0;
        pwrite_o  = '0;
        paddr_o   = '0;
        pwdata_o  = '0;
        if (state_q == SETUP || state_q == ACCESS) begin
            psel_o[sel_q]    = 1'b1;
            penable_o[sel_q] = (state_q == ACCESS);
            pwrite_o[sel_q]  = pwrite_q;
            paddr_o[sel_q]   = addr_q;
            pwdata_o[sel_q]  = wdata_q;
        end
    end

    assign pready_o  = (state_q == RESP) || (state_q == ERR);
    assign prdata_o  = prdata_q;
    assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_node_pipe.sv
// Directed bench for apb_node_pipe: decode, latency, errors, reset.
// Build with +define+APB_NODE_PIPE_TIMEOUT_EN to exercise the timeout path.
module tb_apb_node_pipe;

    localparam int NB = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   psel_i;
    logic                   penable_i;
    logic                   pwrite_i;
    logic [AW-1:0]          paddr_i;
    logic [DW-1:0]          pwdata_i;
    logic [DW-1:0]          prdata_o;
    logic                   pready_o;
    logic                   pslverr_o;
    logic [NB-1:0]          psel_o;
    logic [NB-1:0]          penable_o;
    logic [NB-1:0]          pwrite_o;
    logic [NB-1:0][AW-1:0]  paddr_o;
    logic [NB-1:0][DW-1:0]  pwdata_o;
    logic [NB-1:0][DW-1:0]  prdata_i;
    logic [NB-1:0]          pready_i;
    logic [NB-1:0]          pslverr_i;
    logic [NB-1:0][AW-1:0]  start_addr;
    logic [NB-1:0][AW-1:0]  end_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    apb_node_pipe #(
        .NB_MASTER      (NB),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .psel_i       (psel_i),
        .penable_i    (penable_i),
        .pwrite_i     (pwrite_i),
        .paddr_i      (paddr_i),
        .pwdata_i     (pwdata_i),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i),
        .START_ADDR_i (start_addr),
        .END_ADDR_i   (end_addr)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Presents a setup now, then waits (bounded) for pready_o.
    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] d, output int l);
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = a;
        pwrite_i  = w;
        pwdata_i  = d;
        l = 0;
        for (int c = 1; c <= 30; c++) begin
            tick;
            penable_i = 1'b1;
            if (pready_o) begin
                l = c;
                break;
            end
        end
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i     = 1'b1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        paddr_i   = 32'h1004;
        pwdata_i  = '0;
        prdata_i  = '0;
        pready_i  = '1;
        pslverr_i = '0;
        for (int i = 0; i < NB; i++) begin
            start_addr[i] = 32'hFFFF_FFFF;
            end_addr[i]   = 32'h0;
        end
        start_addr[0] = 32'h0000_0000; end_addr[0] = 32'h0000_0FFF;
        start_addr[1] = 32'h0000_2000; end_addr[1] = 32'h0000_2FFF;
        start_addr[2] = 32'h0000_1000; end_addr[2] = 32'h0000_1FFF;
        start_addr[3] = 32'h0000_2000; end_addr[3] = 32'h0000_3FFF;
        prdata_i[0] = 32'h0000_A5A5;
        prdata_i[1] = 32'h0000_1111;
        prdata_i[2] = 32'hDEAD_BEEF;

        // Reset held with a setup on the bus: nothing may be captured.
        tick;
        tick;
        check("rst_psel", psel_o, 0);
        check("rst_pready", pready_o, 0);
        check("rst_prdata", prdata_o, 0);
        check("rst_pslverr", pslverr_o, 0);
        check("rst_paddr", |paddr_o, 0);
        rst_i  = 1'b0;
        psel_i = 1'b0;
        tick;
        check("post_rst_psel", psel_o, 0);

        // Read hit on port 2, zero-wait slave.
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = 32'h1004;
        pwrite_i  = 1'b0;
        tick;
        check("rd_setup_psel", psel_o, 8'h04);
        check("rd_setup_pen", penable_o, 8'h00);
        check("rd_setup_addr", paddr_o[2], 32'h1004);
        check("rd_setup_rdy", pready_o, 0);
        penable_i = 1'b1;
        tick;
        check("rd_acc_pen", penable_o, 8'h04);
        check("rd_acc_rdy", pready_o, 0);
        tick;
        check("rd_resp_rdy", pready_o, 1);
        check("rd_resp_data", prdata_o, 32'hDEAD_BEEF);
        check("rd_resp_err", pslverr_o, 0);
        check("rd_resp_psel", psel_o, 0);
        psel_i    = 1'b0;
        penable_i = 1'b0;
        tick;
        check("rd_idle_rdy", pready_o, 0);
        check("rd_idle_hold", prdata_o, 32'hDEAD_BEEF);

        // Overlapping windows 1/3, write; setup right after RESP.
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = 32'h2000;
        pwrite_i  = 1'b1;
        pwdata_i  = 32'h55AA;
        tick;
        check("wr_setup_psel", psel_o, 8'h02);
        check("wr_setup_addr", paddr_o[1], 32'h2000);
        check("wr_setup_data", pwdata_o[1], 32'h55AA);
        check("wr_setup_pwr", pwrite_o, 8'h02);
        check("wr_port3_addr", paddr_o[3], 0);
        psel_i    = 1'b0;
        penable_i = 1'b1;
        paddr_i   = 32'h1004;
        pwdata_i  = 32'h0;
        pwrite_i  = 1'b0;
        tick;
        check("wr_acc_psel", psel_o, 8'h02);
        check("wr_acc_pen", penable_o, 8'h02);
        check("wr_acc_addr", paddr_o[1], 32'h2000);
        check("wr_acc_data", pwdata_o[1], 32'h55AA);
        tick;
        check("wr_resp_rdy", pready_o, 1);
        check("wr_resp_data", prdata_o, 32'h1111);
        check("wr_resp_err", pslverr_o, 0);
        penable_i = 1'b0;
        tick;

        // Decode miss goes straight to the error response.
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = 32'hF000_0000;
        tick;
        check("miss_psel", psel_o, 0);
        check("miss_rdy", pready_o, 1);
        check("miss_err", pslverr_o, 1);
        check("miss_data", prdata_o, 0);
        psel_i = 1'b0;
        tick;
        check("miss_idle_rdy", pready_o, 0);
        check("miss_idle_err", pslverr_o, 1);

        // Slave 0: four wait cycles then an error response.
        pready_i[0]  = 1'b0;
        pslverr_i[0] = 1'b1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = 32'h100;
        pwrite_i  = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick;
            penable_i = 1'b1;
            if (pready_o) begin
                lat = c;
                break;
            end
            if (c == 6) pready_i[0] = 1'b1;
        end
        check("wait_lat", lat, 7);
        check("wait_err", pslverr_o, 1);
        check("wait_data", prdata_o, 32'hA5A5);
        psel_i       = 1'b0;
        penable_i    = 1'b0;
        pslverr_i[0] = 1'b0;
        tick;

        // Slave that never answers.
        pready_i[0] = 1'b0;
`ifdef APB_NODE_PIPE_TIMEOUT_EN
        xfer(32'h100, 1'b0, 32'h0, lat);
        check("tmo_lat", lat, 7);
        check("tmo_err", pslverr_o, 1);
        check("tmo_data", prdata_o, 0);
        check("tmo_psel", psel_o, 0);
        tick;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = 32'h100;
        tick;
        penable_i = 1'b1;
        tick;
        check("pre_rst_pen", penable_o, 8'h01);
`else
        xfer(32'h100, 1'b0, 32'h0, lat);
        check("notmo_lat", lat, 0);
        check("notmo_psel", psel_o, 8'h01);
        check("notmo_pen", penable_o, 8'h01);
`endif

        // Reset in the middle of ACCESS.
        rst_i = 1'b1;
        tick;
        check("mid_rst_psel", psel_o, 0);
        check("mid_rst_pen", penable_o, 0);
        check("mid_rst_rdy", pready_o, 0);
        check("mid_rst_err", pslverr_o, 0);
        check("mid_rst_data", prdata_o, 0);
        check("mid_rst_addr", |paddr_o, 0);
        rst_i     = 1'b0;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pready_i  = '1;
        tick;
        xfer(32'h1004, 1'b0, 32'h0, lat);
        check("again_lat", lat, 3);
        check("again_data", prdata_o, 32'hDEAD_BEEF);
        check("again_err", pslverr_o, 0);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
